output_port_fifo: RTL and testbench
===================================

Name: output_port_fifo

Overview:
- Parametrised successor to the single-register CPU output port.
- CPU-side writes are queued in a DEPTH-entry FIFO. A peripheral drains the FIFO over a valid/ready handshake.
- data_out holds the most recently consumed word, so legacy displays and LEDs keep working.
- Sits between the datapath output-write strobe and the board-level output devices.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 4, FIFO entries. Must be a power of two, >=2. Pointer width PW = clog2(DEPTH) is derived internally.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous active-low reset.
- data_in  in  WIDTH  word from datapath.
- outputWrite  in  1  push request, sampled each rising edge.
- clearOverflow  in  1  clears the sticky overflow flag.
- out_data  out  WIDTH  FIFO head word. Valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.
- data_out  out  WIDTH  last word popped. Registered and held.
- count  out  PW+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset: sampled only at the rising edge while reset_n=0. It clears read/write pointers and count to 0, data_out to 0 and overflow to 0, which gives out_valid=0, empty=1, full=0. Storage array is not reset. Reset overrides every other input in the same cycle, including mid-burst; queued words are discarded.
- Storage: DEPTH x WIDTH registers. Pointers wrap modulo DEPTH by natural PW-bit overflow. count tracks occupancy separately, so full and empty are unambiguous.
- out_data: combinational read of entry[rd_ptr]. Bench must not check it while out_valid=0.
- out_valid = !empty, combinational from count.
- pop = out_valid && out_ready. On pop: rd_ptr+1 and data_out <= entry[rd_ptr] at the same edge. data_out is otherwise unchanged.
- push = outputWrite && (!full || pop). On push: entry[wr_ptr] <= data_in and wr_ptr+1.
- Count update: push only, count+1; pop only, count-1; both or neither, unchanged.
- Full and popping: simultaneous push+pop is accepted, count stays DEPTH, and no overflow is flagged.
- Empty: out_ready is ignored, so there is no pop and data_out is unchanged. A push while empty is accepted.
- Latency: a push at edge N gives out_valid=1 and out_data=that word from just after edge N. There is no bypass to data_out; it updates only at the edge of the pop.
- Overflow: outputWrite && full && !pop drops the word (no state change besides the flag) and sets overflow at that edge. overflow clears on clearOverflow=1. If set and clear occur in the same cycle, set wins.
- full, empty and count are combinational from the count register, so they are glitch-free relative to clock.
- No combinational path exists from outputWrite to out_valid or full. Only out_ready affects push acceptance combinationally.

Test Plan:
1. Reset, then push 0x1234 with out_ready=0 -> next cycle out_valid=1, out_data=0x1234, count=1, data_out=0x0000.
2. Push 0xA001..0xA004 (DEPTH=4), out_ready=0 -> full=1, count=4. Fifth push 0xA005 -> dropped, overflow=1. Then drain with out_ready=1 -> data_out sequence A001,A002,A003,A004 on consecutive edges, and never A005.
3. Full FIFO, out_ready=1 and outputWrite=1 with 0xBEEF in the same cycle -> count stays 4, overflow stays 0, and 0xBEEF emerges after the four older words.
4. Push and pop continuously for 3*DEPTH words 0x0000..0x000B -> pointers wrap, output order is preserved, and count oscillates within 0..1.
5. overflow=1; assert clearOverflow and a dropped write together -> overflow stays 1. Next cycle clearOverflow alone -> overflow=0.
6. Count=3 with data_out=0x5555; drive reset_n=0 for one edge while outputWrite=1 and out_ready=1 -> count=0, empty=1, data_out=0, overflow=0, nothing pushed. Empty with out_ready=1 -> data_out holds.

Source files
------------

// File: rtl/output_port_fifo.sv
// output_port_fifo: CPU output-port write queue drained over a valid/ready
// handshake. data_out keeps the last consumed word for legacy displays/LEDs.
module output_port_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             outputWrite,
   input  logic             clearOverflow,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic [PW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic [WIDTH-1:0] r_data_out;
   logic             r_overflow;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // Status flags come only from the count register, never from outputWrite.
   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   always_comb begin
      w_full  = (r_count == (PW+1)'(DEPTH));
      w_empty = (r_count == '0);
      w_pop   = !w_empty && out_ready;
      w_push  = outputWrite && (!w_full || w_pop);
      w_drop  = outputWrite && w_full && !w_pop;
   end

   // Storage array is deliberately left unreset.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= data_in;
   end

   // Pointers, occupancy, last-popped word and sticky overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + PW'(1);
            r_data_out <= r_mem[r_rd_ptr];
         end
         if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop)             r_overflow <= 1'b1;
         else if (clearOverflow) r_overflow <= 1'b0;
      end
   end

   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = !w_empty;
   assign data_out  = r_data_out;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_output_port_fifo.sv
// Self-checking bench for output_port_fifo: reference queue model used as a
// scoreboard, a vector table for the fill/overflow/drain pattern, and
// hand-written sequences for the remaining corner cases.
module tb_output_port_fifo;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH);

   logic             clock = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] data_in;
   logic             outputWrite;
   logic             clearOverflow;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic [PW:0]      count;
   logic             full;
   logic             empty;
   logic             overflow;

   output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in),
      .outputWrite(outputWrite), .clearOverflow(clearOverflow),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .count(count), .full(full), .empty(empty),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // scoreboard / reference model
   logic [WIDTH-1:0] m_q [$];
   logic [WIDTH-1:0] m_dout;
   logic             m_ovf;

   typedef struct {
      logic             wr;
      logic [WIDTH-1:0] din;
      logic             rdy;
      logic             clr;
      int               exp_cnt;
      logic             exp_ovf;
      logic [WIDTH-1:0] exp_dout;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, predict, check #1 after the rising edge.
   task automatic step(input logic rst, input logic wr, input logic [WIDTH-1:0] din,
                       input logic rdy, input logic clr);
      logic pop, push, drop;
      @(negedge clock);
      reset_n = !rst; outputWrite = wr; data_in = din; out_ready = rdy; clearOverflow = clr;
      #1;
      // outputWrite must not reach out_valid/full combinationally
      chk("pre_valid", out_valid, m_q.size() != 0);
      chk("pre_full", full, m_q.size() == DEPTH);
      pop  = (m_q.size() != 0) && rdy;
      push = wr && ((m_q.size() < DEPTH) || pop);
      drop = wr && (m_q.size() == DEPTH) && !pop;
      @(posedge clock);
      #1;
      if (rst) begin
         m_q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
      end else begin
         if (pop)  m_dout = m_q.pop_front();
         if (push) m_q.push_back(din);
         if (drop)     m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      chk("count", count, m_q.size());
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("data_out", data_out, m_dout);
      chk("overflow", overflow, m_ovf);
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
   endtask

   initial begin
      reset_n = 1'b0; outputWrite = 1'b0; data_in = '0; out_ready = 1'b0; clearOverflow = 1'b0;
      m_dout = '0; m_ovf = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_ovf", overflow, 0);

      // 1: single push, visible right after the edge, data_out untouched
      step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
      chk("t1_data", out_data, 16'h1234);
      chk("t1_dout", data_out, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t1_pop", data_out, 16'h1234);

      // 2: fill, overflow, drain (table-driven)
      vecs[0] = '{1'b1, 16'hA001, 1'b0, 1'b0, 1, 1'b0, 16'h1234};
      vecs[1] = '{1'b1, 16'hA002, 1'b0, 1'b0, 2, 1'b0, 16'h1234};
      vecs[2] = '{1'b1, 16'hA003, 1'b0, 1'b0, 3, 1'b0, 16'h1234};
      vecs[3] = '{1'b1, 16'hA004, 1'b0, 1'b0, 4, 1'b0, 16'h1234};
      vecs[4] = '{1'b1, 16'hA005, 1'b0, 1'b0, 4, 1'b1, 16'h1234};
      vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1, 16'hA001};
      vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 16'hA002};
      vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'hA003};
      vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'hA004};
      vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'hA004};
      for (int i = 0; i < 10; i++) begin
         step(1'b0, vecs[i].wr, vecs[i].din, vecs[i].rdy, vecs[i].clr);
         chk($sformatf("t2_cnt[%0d]", i), count, vecs[i].exp_cnt);
         chk($sformatf("t2_ovf[%0d]", i), overflow, vecs[i].exp_ovf);
         chk($sformatf("t2_dout[%0d]", i), data_out, vecs[i].exp_dout);
      end

      // 3: full with simultaneous push+pop
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
      chk("t3_cnt", count, 4);
      chk("t3_ovf", overflow, 0);
      chk("t3_dout", data_out, 16'hB000);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t3_beef", data_out, 16'hBEEF);
      chk("t3_empty", empty, 1);

      // 4: streaming 3*DEPTH words through, pointers wrap
      for (int i = 0; i < 3*DEPTH; i++) begin
         step(1'b0, 1'b1, 16'(i), 1'b1, 1'b0);
         chk("t4_cnt_le1", count <= 1, 1);
      end
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t4_last", data_out, 16'h000B);

      // 5: set beats clear, then clear alone
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
      chk("t5_ovf_set", overflow, 1);
      step(1'b0, 1'b1, 16'hC0FF, 1'b0, 1'b1);
      chk("t5_set_wins", overflow, 1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t5_cleared", overflow, 0);

      // 6: reset mid-burst discards everything
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
      chk("t6_pre_cnt", count, 3);
      chk("t6_pre_dout", data_out, 16'h5555);
      step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
      chk("t6_cnt", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_dout", data_out, 0);
      chk("t6_ovf", overflow, 0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t6_hold", data_out, 0);
      chk("t6_still_empty", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
